bus_lane_splitter: RTL
======================

// Module: bus_lane_splitter
// PURPOSE
//  Parametrised bus splitter. Accepts a word of LANES x LANE_W bits over a valid/ready handshake.
//  Parallel mode: all lanes are presented at once.
//  Serial mode: one lane is emitted per handshake, with lane index and last flag.
//  Sits between wide datapath buses and narrow per-lane consumers; supersedes fixed 8x1 splitters.
// PARAMETERS
//  LANES   8  number of lanes in the input word (>=2)
//  LANE_W  1  bits per lane (>=1)
//  IDX_W   $clog2(LANES)  width of lane index (derived localparam, not overridable)
// PORTS
//  clk        in   1             rising-edge clock, single clock domain
//  rst_n      in   1             synchronous, active-low reset
//  mode       in   1             0 = parallel, 1 = serial; sampled only on input accept
//  in_valid   in   1             input word valid
//  in_ready   out  1             block can accept a word this cycle
//  in_data    in   LANES*LANE_W  input word; lane i = in_data[i*LANE_W +: LANE_W]
//  out_valid  out  1             output beat valid
//  out_ready  in   1             consumer accepts beat
//  lanes_out  out  LANES*LANE_W  registered copy of last accepted word, lane-split as in_data
//  ser_data   out  LANE_W        current serial lane value (serial mode)
//  ser_idx    out  IDX_W         index of current serial lane
//  out_last   out  1             final beat of current word
//  busy       out  1             state != IDLE
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge):
//    - state=IDLE; out_valid, lanes_out, ser_data, ser_idx, out_last all 0.
//    - in_ready=0 while rst_n=0.
//    - Reset mid-word discards the word; no further beats of it are issued.
//  - FSM states:
//    - IDLE: out_valid=0, in_ready=1. On in_valid: capture in_data into word_q and lanes_out,
//      latch mode_q=mode. Go to HOLD (mode 0) or SHIFT with ser_idx=0 (mode 1).
//    - HOLD: out_valid=1, out_last=1. On out_ready: done.
//    - SHIFT: out_valid=1, ser_data=word_q lane ser_idx, out_last=(ser_idx==LANES-1).
//      On out_ready && !out_last: ser_idx+1. On out_ready && out_last: done.
//  - Latency: first output beat is valid the cycle after input accept.
//  - Done: in_ready = (state==IDLE) || (out_valid && out_ready && out_last); combinational from out_ready.
//    - If in_valid is high in the done cycle, the next word is captured with no bubble.
//      Next state is HOLD/SHIFT per the new mode.
//    - Otherwise next state is IDLE.
//  - lanes_out updates only on input accept (any mode) and is stable otherwise, including in IDLE.
//  - ser_data and ser_idx hold their values in HOLD/IDLE.
//  - Beat-level handshake:
//    - out_valid, once high, never drops until the beat is taken.
//    - mode changes mid-word are ignored.
//  - ser_idx never wraps past LANES-1; it reloads to 0 on accept.
// CONFIGURATION
//  LANE_MASK_EN defined:
//    - Adds input port lane_mask [LANES], sampled with in_data on accept.
//    - Serial mode: lanes with mask bit 0 are skipped. First beat = lowest set bit;
//      ser_idx steps to the next set bit; out_last marks the highest set bit.
//    - Parallel mode: masked lanes read 0 on lanes_out.
//    - lane_mask==0: word is accepted but produces no beats. FSM returns to IDLE;
//      in_ready=1 the next cycle; lanes_out=0.
//  LANE_MASK_EN undefined: no lane_mask port; all lanes enabled; behaviour as above.
// TESTING (LANES=8, LANE_W=1 unless stated)
//  1 Reset: rst_n=0 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, lanes_out=0.
//    Cycle after release -> in_ready=1.
//  2 Parallel: mode=0, in_data=8'hA5 accepted -> next cycle out_valid=1, lanes_out=8'hA5, out_last=1.
//    Hold out_ready=0 for 3 cycles -> values stable; out_ready=1 -> handshake, IDLE.
//  3 Serial: mode=1, in_data=8'b1011_0010, out_ready=1 -> 8 beats, ser_data 0,1,0,0,1,1,0,1,
//    ser_idx 0..7, out_last only at 7. Second word offered at the last beat is accepted that
//    cycle; its first beat follows with no gap.
//  4 Backpressure: serial word, out_ready toggled 1,0,0,1,... -> ser_idx advances only on handshake.
//    mode flipped to 0 mid-word -> remaining beats still serial.
//  5 Mid-word reset: assert rst_n=0 at ser_idx=3 -> next cycle out_valid=0, ser_idx=0, busy=0.
//  6 LANE_MASK_EN, LANE_W=4:
//    - mask=8'b1000_0101 -> beats at ser_idx 0,2,7 only, out_last at 7.
//    - mask=0 -> zero beats, in_ready=1 the next cycle.

Source files
------------

// File: rtl/bus_lane_splitter_if.sv
// Handshake bus for bus_lane_splitter.
// Upstream/consumer side uses modport master, the splitter uses modport slave.
// Optional macro LANE_MASK_EN adds the lane_mask input.
// Signals: mode, in_valid, in_ready, in_data, out_valid, out_ready, lanes_out,
//          ser_data, ser_idx, out_last, busy [, lane_mask]
interface bus_lane_splitter_if #(
  parameter int unsigned LANES  = 8,
  parameter int unsigned LANE_W = 1
);
  localparam int unsigned IDX_W = $clog2(LANES);
  localparam int unsigned W     = LANES * LANE_W;

  logic              mode;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_data;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      lanes_out;
  logic [LANE_W-1:0] ser_data;
  logic [IDX_W-1:0]  ser_idx;
  logic              out_last;
  logic              busy;
`ifdef LANE_MASK_EN
  logic [LANES-1:0]  lane_mask;
`endif

  modport master (
`ifdef LANE_MASK_EN
    output lane_mask,
`endif
    output mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, lanes_out, ser_data, ser_idx, out_last, busy
  );

  modport slave (
`ifdef LANE_MASK_EN
    input  lane_mask,
`endif
    input  mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, lanes_out, ser_data, ser_idx, out_last, busy
  );
endinterface

// File: rtl/bus_lane_splitter.sv
// Parametrised lane splitter: accepts LANES x LANE_W words over valid/ready and
// presents them either whole (parallel, one beat) or one lane per beat (serial).
// Ports: clk, rst_n (synchronous, active-low), bus (bus_lane_splitter_if.slave).
// Optional macro LANE_MASK_EN: per-word lane_mask skips disabled lanes in serial
// mode and zeroes them on lanes_out.
// The LANES/LANE_W parameters must match those of the connected interface.
module bus_lane_splitter #(
  parameter int unsigned LANES  = 8,
  parameter int unsigned LANE_W = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  bus_lane_splitter_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(LANES);
  localparam int unsigned W     = LANES * LANE_W;

  typedef enum logic [1:0] {IDLE, HOLD, SHIFT} state_t;

  state_t            state_q, state_d;
  logic [W-1:0]      word_q, word_in;
  logic [LANES-1:0]  mask_in, mask_q;
  logic [IDX_W-1:0]  ser_idx_q, last_idx_q;
  logic [IDX_W-1:0]  first_idx, hi_idx, nxt_idx;
  logic [LANE_W-1:0] ser_data_q;
  logic [LANE_W-1:0] in_lane [LANES];
  logic [LANE_W-1:0] q_lane  [LANES];
  logic              out_valid, out_last, done, in_ready, accept, advance;

`ifdef LANE_MASK_EN
  assign mask_in = bus.lane_mask;
`else
  assign mask_in = '1;
`endif

  // Lane views of the incoming (masked) word and of the captured word
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign word_in[g*LANE_W +: LANE_W] = mask_in[g] ? bus.in_data[g*LANE_W +: LANE_W]
                                                    : LANE_W'(0);
    assign in_lane[g] = word_in[g*LANE_W +: LANE_W];
    assign q_lane[g]  = word_q[g*LANE_W +: LANE_W];
  end

  // Lowest/highest enabled lane of the new word, next enabled lane of the current one
  always_comb begin
    first_idx = '0;
    hi_idx    = '0;
    nxt_idx   = ser_idx_q;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask_in[i]) first_idx = IDX_W'(i);
      if (mask_q[i] && (IDX_W'(i) > ser_idx_q)) nxt_idx = IDX_W'(i);
    end
    for (int i = 0; i < LANES; i++) begin
      if (mask_in[i]) hi_idx = IDX_W'(i);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and beat decode; in_ready is combinational from out_ready so a
  // new word can be taken in the same cycle as the final beat
  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state_q)
      HOLD: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
      end
      SHIFT: begin
        out_valid = 1'b1;
        out_last  = (ser_idx_q == last_idx_q);
      end
      default: ;
    endcase
    done     = out_valid && bus.out_ready && out_last;
    advance  = (state_q == SHIFT) && bus.out_ready && !out_last;
    in_ready = rst_n && ((state_q == IDLE) || done);
    accept   = in_ready && bus.in_valid;
    if (accept) begin
      // A fully masked word is absorbed without producing beats
      if (mask_in == '0)  state_d = IDLE;
      else if (bus.mode)  state_d = SHIFT;
      else                state_d = HOLD;
    end else if (done) begin
      state_d = IDLE;
    end
  end

  // Word capture and serial lane pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q     <= '0;
      mask_q     <= '0;
      last_idx_q <= '0;
      ser_idx_q  <= '0;
      ser_data_q <= '0;
    end else if (accept) begin
      word_q     <= word_in;
      mask_q     <= mask_in;
      last_idx_q <= hi_idx;
      if (bus.mode && (mask_in != '0)) begin
        ser_idx_q  <= first_idx;
        ser_data_q <= in_lane[first_idx];
      end
    end else if (advance) begin
      ser_idx_q  <= nxt_idx;
      ser_data_q <= q_lane[nxt_idx];
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign bus.lanes_out = word_q;
  assign bus.ser_data  = ser_data_q;
  assign bus.ser_idx   = ser_idx_q;
  assign bus.busy      = (state_q != IDLE);
endmodule
